// File: rtl/bus_master_arbiter.sv
// Two-master, one-slave bus arbiter. Alternates between masters A and B on
// simultaneous requests, forwards the granted master's cycle to the slave and
// force-completes a grant with read data 16'hFFFF if the slave never acks.
module bus_master_arbiter #(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        reset,

  // Master A
  input  logic [19:1] a_m_addr,
  input  logic [15:0] a_m_data_out,
  output logic [15:0] a_m_data_in,
  input  logic        a_m_access,
  output logic        a_m_ack,
  input  logic        a_m_wr_en,
  input  logic [1:0]  a_m_bytesel,

  // Master B
  input  logic [19:1] b_m_addr,
  input  logic [15:0] b_m_data_out,
  output logic [15:0] b_m_data_in,
  input  logic        b_m_access,
  output logic        b_m_ack,
  input  logic        b_m_wr_en,
  input  logic [1:0]  b_m_bytesel,

  // Slave
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  input  logic [15:0] q_m_data_in,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,

  output logic        timeout
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrantA = 2'b01,
    StGrantB = 2'b10
  } state_e;

  // Last wait-counter value before a grant is force-completed.
  localparam logic [15:0] WaitLimit = 16'(timeout_cycles - 1);

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0 = A, 1 = B
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // Signals of whichever master currently owns the bus.
  logic        granted;
  logic        sel_b;
  logic [19:1] m_addr;
  logic [15:0] m_data_out;
  logic        m_access;
  logic        m_wr_en;
  logic [1:0]  m_bytesel;

  // Response produced for the owning master, steered to A or B below.
  logic        m_ack;
  logic [15:0] m_data_in;
  logic        force_done;

  // Select the owning master's request fields.
  always_comb begin
    granted    = (state_q == StGrantA) || (state_q == StGrantB);
    sel_b      = (state_q == StGrantB);
    m_addr     = sel_b ? b_m_addr     : a_m_addr;
    m_data_out = sel_b ? b_m_data_out : a_m_data_out;
    m_access   = sel_b ? b_m_access   : a_m_access;
    m_wr_en    = sel_b ? b_m_wr_en    : a_m_wr_en;
    m_bytesel  = sel_b ? b_m_bytesel  : a_m_bytesel;
  end

  // Next-state logic, slave-side drive and response generation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;

    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = '0;

    m_ack        = 1'b0;
    m_data_in    = '0;
    force_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie, A wins only when B was the last one served.
        if (a_m_access && (!b_m_access || last_grant_q)) begin
          state_d      = StGrantA;
          last_grant_d = 1'b0;
          wait_cnt_d   = '0;
        end else if (b_m_access) begin
          state_d      = StGrantB;
          last_grant_d = 1'b1;
          wait_cnt_d   = '0;
        end
      end

      StGrantA, StGrantB: begin
        q_m_addr     = m_addr;
        q_m_data_out = m_data_out;
        q_m_access   = m_access;
        q_m_wr_en    = m_wr_en;
        q_m_bytesel  = m_bytesel;
        m_data_in    = q_m_data_in;

        if (!m_access) begin
          // Master withdrew before any ack: abandon quietly.
          state_d = StIdle;
        end else if (q_m_ack) begin
          // A real ack beats a coincident timeout.
          m_ack   = 1'b1;
          state_d = StIdle;
        end else if (wait_cnt_q == WaitLimit) begin
          m_ack      = 1'b1;
          m_data_in  = 16'hFFFF;
          q_m_access = 1'b0;
          force_done = 1'b1;
          state_d    = StIdle;
        end else if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Route the response to the owner; the other master always sees zeros.
  always_comb begin
    a_m_ack     = 1'b0;
    a_m_data_in = '0;
    b_m_ack     = 1'b0;
    b_m_data_in = '0;
    if (granted && !sel_b) begin
      a_m_ack     = m_ack;
      a_m_data_in = m_data_in;
    end
    if (granted && sel_b) begin
      b_m_ack     = m_ack;
      b_m_data_in = m_data_in;
    end
    timeout = force_done;
  end

  // State, last-grant and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Bench for bus_master_arbiter: directed scenarios followed by randomized
// master/slave traffic, every cycle compared against a transaction-level model.
module tb_bus_master_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] a_m_addr, b_m_addr, q_m_addr;
  logic [15:0] a_m_data_out, b_m_data_out, q_m_data_out;
  logic [15:0] a_m_data_in, b_m_data_in, q_m_data_in;
  logic        a_m_access, b_m_access, q_m_access;
  logic        a_m_ack, b_m_ack, q_m_ack;
  logic        a_m_wr_en, b_m_wr_en, q_m_wr_en;
  logic [1:0]  a_m_bytesel, b_m_bytesel, q_m_bytesel;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: owner 0 = none, 1 = A, 2 = B; grant age from cycle stamps.
  int owner = 0;
  int last = 2;
  int cyc = 0;
  int grant_start = 0;

  logic [19:1] ex_q_addr;
  logic [15:0] ex_q_dout, ex_a_din, ex_b_din;
  logic        ex_q_acc, ex_q_wr, ex_a_ack, ex_b_ack, ex_to;
  logic [1:0]  ex_q_bs;

  logic a_got, b_got;

  always #5 clk = ~clk;

  bus_master_arbiter #(.timeout_cycles(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_m_addr     (a_m_addr),
    .a_m_data_out (a_m_data_out),
    .a_m_data_in  (a_m_data_in),
    .a_m_access   (a_m_access),
    .a_m_ack      (a_m_ack),
    .a_m_wr_en    (a_m_wr_en),
    .a_m_bytesel  (a_m_bytesel),
    .b_m_addr     (b_m_addr),
    .b_m_data_out (b_m_data_out),
    .b_m_data_in  (b_m_data_in),
    .b_m_access   (b_m_access),
    .b_m_ack      (b_m_ack),
    .b_m_wr_en    (b_m_wr_en),
    .b_m_bytesel  (b_m_bytesel),
    .q_m_addr     (q_m_addr),
    .q_m_data_out (q_m_data_out),
    .q_m_data_in  (q_m_data_in),
    .q_m_access   (q_m_access),
    .q_m_ack      (q_m_ack),
    .q_m_wr_en    (q_m_wr_en),
    .q_m_bytesel  (q_m_bytesel),
    .timeout      (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected outputs this cycle from the current owner and live inputs.
  task automatic model_outputs();
    int age;
    logic acc, to;
    age       = cyc - grant_start;
    ex_q_addr = '0; ex_q_dout = '0; ex_q_acc = 1'b0; ex_q_wr = 1'b0; ex_q_bs = '0;
    ex_a_ack  = 1'b0; ex_a_din = '0; ex_b_ack = 1'b0; ex_b_din = '0; ex_to = 1'b0;
    if (owner != 0) begin
      acc       = (owner == 1) ? a_m_access : b_m_access;
      to        = acc && !q_m_ack && (age == TO - 1);
      ex_q_addr = (owner == 1) ? a_m_addr : b_m_addr;
      ex_q_dout = (owner == 1) ? a_m_data_out : b_m_data_out;
      ex_q_wr   = (owner == 1) ? a_m_wr_en : b_m_wr_en;
      ex_q_bs   = (owner == 1) ? a_m_bytesel : b_m_bytesel;
      ex_q_acc  = acc && !to;
      ex_to     = to;
      if (owner == 1) begin
        ex_a_ack = (acc && q_m_ack) || to;
        ex_a_din = to ? 16'hFFFF : q_m_data_in;
      end else begin
        ex_b_ack = (acc && q_m_ack) || to;
        ex_b_din = to ? 16'hFFFF : q_m_data_in;
      end
    end
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    int age, g;
    logic acc;
    age = cyc - grant_start;
    acc = (owner == 1) ? a_m_access : b_m_access;
    if (reset) begin
      owner = 0;
      last  = 2;
    end else if (owner != 0) begin
      if (!acc || q_m_ack || age == TO - 1) owner = 0;
    end else begin
      g = 0;
      if (a_m_access && b_m_access) g = (last == 1) ? 2 : 1;
      else if (a_m_access) g = 1;
      else if (b_m_access) g = 2;
      if (g != 0) begin
        owner       = g;
        last        = g;
        grant_start = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    model_outputs();
    check("q_addr", 32'(q_m_addr), 32'(ex_q_addr));
    check("q_dout", 32'(q_m_data_out), 32'(ex_q_dout));
    check("q_access", 32'(q_m_access), 32'(ex_q_acc));
    check("q_wr_en", 32'(q_m_wr_en), 32'(ex_q_wr));
    check("q_bytesel", 32'(q_m_bytesel), 32'(ex_q_bs));
    check("a_ack", 32'(a_m_ack), 32'(ex_a_ack));
    check("a_din", 32'(a_m_data_in), 32'(ex_a_din));
    check("b_ack", 32'(b_m_ack), 32'(ex_b_ack));
    check("b_din", 32'(b_m_data_in), 32'(ex_b_din));
    check("timeout", 32'(timeout), 32'(ex_to));
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_random();
    reset = ($urandom_range(99, 0) == 0);
    if (a_m_access) begin
      if (a_got || $urandom_range(49, 0) == 0) a_m_access = 1'b0;
    end else if ($urandom_range(2, 0) == 0) begin
      a_m_access   = 1'b1;
      a_m_addr     = 19'($urandom);
      a_m_data_out = 16'($urandom);
      a_m_wr_en    = 1'($urandom);
      a_m_bytesel  = 2'($urandom);
    end
    if (b_m_access) begin
      if (b_got || $urandom_range(49, 0) == 0) b_m_access = 1'b0;
    end else if ($urandom_range(2, 0) == 0) begin
      b_m_access   = 1'b1;
      b_m_addr     = 19'($urandom);
      b_m_data_out = 16'($urandom);
      b_m_wr_en    = 1'($urandom);
      b_m_bytesel  = 2'($urandom);
    end
    q_m_ack     = ($urandom_range(3, 0) == 0);
    q_m_data_in = 16'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_m_addr = '0; a_m_data_out = '0; a_m_access = 1'b0; a_m_wr_en = 1'b0; a_m_bytesel = '0;
    b_m_addr = '0; b_m_data_out = '0; b_m_access = 1'b0; b_m_wr_en = 1'b0; b_m_bytesel = '0;
    q_m_data_in = '0; q_m_ack = 1'b0;
    a_got = 1'b0; b_got = 1'b0;
    @(posedge clk);
    model_edge();
    #1;

    // Reset state.
    settle();
    check("rst_q_access", 32'(q_m_access), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    adv();
    reset = 1'b0;

    // Single A read with ack on the third grant cycle.
    a_m_access = 1'b1; a_m_addr = 19'h00010; a_m_bytesel = 2'b11;
    settle(); check("lat_idle", 32'(q_m_access), 32'd0); adv();
    settle(); check("lat_grant", 32'(q_m_access), 32'd1);
    check("lat_addr", 32'(q_m_addr), 32'h10); adv();
    settle(); adv();
    q_m_ack = 1'b1; q_m_data_in = 16'h1234;
    settle(); check("rd_ack", 32'(a_m_ack), 32'd1);
    check("rd_din", 32'(a_m_data_in), 32'h1234);
    check("rd_b_ack", 32'(b_m_ack), 32'd0); adv();
    a_m_access = 1'b0; q_m_ack = 1'b0;
    settle(); check("rd_idle", 32'(q_m_access), 32'd0); adv();

    // Ties after reset: A, then B, then A again.
    reset = 1'b1; settle(); adv(); reset = 1'b0;
    a_m_access = 1'b1; a_m_addr = 19'h1;
    b_m_access = 1'b1; b_m_addr = 19'h2; b_m_wr_en = 1'b1; b_m_bytesel = 2'b10;
    b_m_data_out = 16'hBEEF;
    settle(); adv();
    q_m_ack = 1'b1; q_m_data_in = 16'h0A0A;
    settle(); check("tie1_addr", 32'(q_m_addr), 32'h1);
    check("tie1_b_ack", 32'(b_m_ack), 32'd0); adv();
    a_m_access = 1'b0; q_m_ack = 1'b0;
    settle(); check("tie_gap", 32'(q_m_access), 32'd0); adv();
    a_m_access = 1'b1;
    settle(); check("tie2_addr", 32'(q_m_addr), 32'h2);
    check("bw_wr", 32'(q_m_wr_en), 32'd1);
    check("bw_bs", 32'(q_m_bytesel), 32'h2);
    check("bw_dout", 32'(q_m_data_out), 32'hBEEF);
    check("a_pend_ack", 32'(a_m_ack), 32'd0);
    check("a_pend_din", 32'(a_m_data_in), 32'd0); adv();
    q_m_ack = 1'b1; q_m_data_in = 16'h5555;
    settle(); check("bw_ack", 32'(b_m_ack), 32'd1);
    check("bw_a_din", 32'(a_m_data_in), 32'd0); adv();
    a_m_access = 1'b0; b_m_access = 1'b0; q_m_ack = 1'b0;
    settle(); adv();
    a_m_access = 1'b1; b_m_access = 1'b1;
    settle(); adv();
    settle(); check("tie3_addr", 32'(q_m_addr), 32'h1); adv();
    q_m_ack = 1'b1;
    settle(); adv();
    a_m_access = 1'b0; b_m_access = 1'b0; q_m_ack = 1'b0;
    settle(); adv();
    settle(); adv();

    // Slave never acks: forced completion on grant cycle TO.
    a_m_access = 1'b1;
    settle(); adv();
    for (int k = 1; k < TO; k++) begin
      settle(); check("to_early", 32'(timeout), 32'd0);
      check("to_early_acc", 32'(q_m_access), 32'd1); adv();
    end
    settle(); check("to_ack", 32'(a_m_ack), 32'd1);
    check("to_din", 32'(a_m_data_in), 32'hFFFF);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_q_acc", 32'(q_m_access), 32'd0); adv();
    a_m_access = 1'b0;
    settle(); check("to_after", 32'(timeout), 32'd0); adv();
    a_m_access = 1'b1;
    settle(); adv();
    q_m_ack = 1'b1; q_m_data_in = 16'h0042;
    settle(); check("to_next_din", 32'(a_m_data_in), 32'h42);
    check("to_next_ack", 32'(a_m_ack), 32'd1); adv();
    a_m_access = 1'b0; q_m_ack = 1'b0;
    settle(); adv();

    // Ack coincident with the timeout cycle.
    a_m_access = 1'b1;
    settle(); adv();
    for (int k = 1; k < TO; k++) begin
      settle(); adv();
    end
    q_m_ack = 1'b1; q_m_data_in = 16'h7777;
    settle(); check("co_din", 32'(a_m_data_in), 32'h7777);
    check("co_to", 32'(timeout), 32'd0);
    check("co_ack", 32'(a_m_ack), 32'd1); adv();
    a_m_access = 1'b0; q_m_ack = 1'b0;
    settle(); adv();

    // Reset in grant cycle 2, then a stray slave ack.
    a_m_access = 1'b1;
    settle(); adv();
    settle(); adv();
    reset = 1'b1;
    settle(); check("rg_ack", 32'(a_m_ack), 32'd0); adv();
    q_m_ack = 1'b1; q_m_data_in = 16'h9999;
    settle(); check("rg_q_acc", 32'(q_m_access), 32'd0);
    check("rg_a_ack", 32'(a_m_ack), 32'd0);
    check("rg_a_din", 32'(a_m_data_in), 32'd0); adv();
    reset = 1'b0; a_m_access = 1'b0;
    settle(); check("stray_a_ack", 32'(a_m_ack), 32'd0);
    check("stray_b_ack", 32'(b_m_ack), 32'd0); adv();
    q_m_ack = 1'b0;
    settle(); adv();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      settle();
      a_got = a_m_ack;
      b_got = b_m_ack;
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
